// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch sequencer: PC, fetch FIFO to decode, redirect and fault trap
// Define FETCH_PERF_CNT_EN to add perf_fetched / perf_redirects counters.
module inst_fetch_ctrl #(
   parameter int              XLEN       = 64,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              IMEM_BYTES = 512,
   parameter int              QDEPTH     = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_inst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   output logic [31:0]     dec_inst,
   output logic [XLEN-1:0] dec_pc,
   input  logic            dec_ready,
   output logic            fault,
   output logic [XLEN-1:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_redirects
`endif
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH) + 1;
   // Highest word address whose last byte still lies inside the memory.
   localparam logic [XLEN-1:0] LAST_OK = XLEN'(IMEM_BYTES - 4);

   typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;
   state_t state, state_n;

   logic [XLEN-1:0]  pc, pc_n, fault_pc_n;
   logic [CW-1:0]    count, count_n;
   logic [AW-1:0]    rd_ptr, rd_ptr_n, wr_ptr;
   logic [XLEN+31:0] mem [QDEPTH];
   logic [XLEN+31:0] head_n;
   logic             push, pop, flush, fault_n;

   function automatic logic addr_ok(input logic [XLEN-1:0] a);
      return (a[1:0] == 2'b00) && (a <= LAST_OK);
   endfunction

   assign imem_addr = pc;
   assign dec_valid = (count != '0);
   assign pop       = dec_valid && dec_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      push       = 1'b0;
      flush      = 1'b0;
      fault_n    = fault;
      fault_pc_n = fault_pc;
      case (state)
         IDLE: begin
            state_n = FETCH;
            if (redirect_valid) begin
               flush = 1'b1;
               pc_n  = redirect_pc;
            end
         end
         FETCH: begin
            if (redirect_valid) begin
               flush = 1'b1;
               pc_n  = redirect_pc;
            end else if (!addr_ok(pc)) begin
               fault_n    = 1'b1;
               fault_pc_n = pc;
               state_n    = FAULT;
            end else if ((count < CW'(QDEPTH)) || pop) begin
               push = 1'b1;
               pc_n = pc + XLEN'(4);
            end
         end
         FAULT: begin
            if (redirect_valid) begin
               flush = 1'b1;
               pc_n  = redirect_pc;
               if (addr_ok(redirect_pc)) begin
                  fault_n = 1'b0;
                  state_n = FETCH;
               end else begin
                  fault_pc_n = redirect_pc;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Next head: the word being pushed when it lands in the slot the read pointer moves to.
   always_comb begin
      rd_ptr_n = rd_ptr + AW'(pop);
      count_n  = count + CW'(push) - CW'(pop);
      if (push && (rd_ptr_n == wr_ptr)) head_n = {pc, imem_inst};
      else                              head_n = mem[rd_ptr_n];
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {pc, imem_inst};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= RESET_PC;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         dec_inst <= '0;
         dec_pc   <= '0;
         fault    <= 1'b0;
         fault_pc <= '0;
      end else begin
         pc       <= pc_n;
         fault    <= fault_n;
         fault_pc <= fault_pc_n;
         if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            count  <= count_n;
            rd_ptr <= rd_ptr_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (count_n != '0) {dec_pc, dec_inst} <= head_n;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched   <= '0;
         perf_redirects <= '0;
      end else begin
         if (push)  perf_fetched   <= perf_fetched + 32'd1;
         if (flush) perf_redirects <= perf_redirects + 32'd1;
      end
   end
`endif

endmodule
